// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: data-memory access, sub-word alignment, writeback
module mem_stage #(
  parameter int XLEN  = 32,
  parameter int RF_AW = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid_i,
  output logic             ex_ready_o,
  output logic             stall_o,
  input  logic             ex_load_i,
  input  logic             ex_store_i,
  input  logic [2:0]       ex_funct3_i,
  input  logic [XLEN-1:0]  ex_result_i,
  input  logic [XLEN-1:0]  ex_wdata_i,
  input  logic [RF_AW-1:0] ex_rd_i,
  input  logic             ex_rd_we_i,
  output logic             dmem_req_o,
  output logic             dmem_we_o,
  output logic [XLEN-1:0]  dmem_addr_o,
  output logic [3:0]       dmem_be_o,
  output logic [XLEN-1:0]  dmem_wdata_o,
  input  logic             dmem_gnt_i,
  input  logic             dmem_rvalid_i,
  input  logic [XLEN-1:0]  dmem_rdata_i,
  output logic             wb_valid_o,
  output logic             wb_we_o,
  output logic [RF_AW-1:0] wb_rd_o,
  output logic [XLEN-1:0]  wb_data_o,
  output logic             mem_err_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R} state_t;

  state_t           r_state, w_state_nxt;
  logic             w_accept, w_mem, w_err, w_issue;
  logic [1:0]       w_off;
  logic [3:0]       w_be;
  logic [XLEN-1:0]  w_wdata, w_lane, w_load_data;
  logic             w_wb_valid_nxt, w_wb_we_nxt, w_err_nxt;
  logic [RF_AW-1:0] w_wb_rd_nxt;
  logic [XLEN-1:0]  w_wb_data_nxt;

  logic             r_we, r_rd_we, r_wb_valid, r_wb_we, r_mem_err;
  logic [XLEN-1:0]  r_addr, r_wdata, r_wb_data;
  logic [3:0]       r_be;
  logic [2:0]       r_f3;
  logic [1:0]       r_off;
  logic [RF_AW-1:0] r_rd, r_wb_rd;

  assign w_accept = ex_valid_i & ex_ready_o;
  assign w_mem    = ex_load_i | ex_store_i;
  assign w_off    = ex_result_i[1:0];
  assign w_issue  = w_accept & w_mem & ~w_err;

  // Illegal funct3 or misaligned address on a memory op
  always_comb begin
    w_err = 1'b0;
    case (ex_funct3_i)
      3'b000:  w_err = 1'b0;
      3'b001:  w_err = w_off[0];
      3'b010:  w_err = |w_off;
      3'b100:  w_err = ex_store_i;
      3'b101:  w_err = ex_store_i | w_off[0];
      default: w_err = 1'b1;
    endcase
    w_err = w_err & w_mem;
  end

  // Byte enables and lane-replicated store data for the access size
  always_comb begin
    w_be    = 4'hF;
    w_wdata = ex_wdata_i;
    case (ex_funct3_i[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{ex_wdata_i[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << w_off;
        w_wdata = {2{ex_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Shift the addressed lane down and sign/zero extend
  always_comb begin
    w_lane      = dmem_rdata_i >> {r_off, 3'b000};
    w_load_data = dmem_rdata_i;
    case (r_f3)
      3'b000:  w_load_data = {{(XLEN-8){w_lane[7]}}, w_lane[7:0]};
      3'b001:  w_load_data = {{(XLEN-16){w_lane[15]}}, w_lane[15:0]};
      3'b100:  w_load_data = {{(XLEN-8){1'b0}}, w_lane[7:0]};
      3'b101:  w_load_data = {{(XLEN-16){1'b0}}, w_lane[15:0]};
      default: w_load_data = dmem_rdata_i;
    endcase
  end

  // State register; async reset drops the bus request immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next state and the writeback values to be registered
  always_comb begin
    w_state_nxt    = r_state;
    w_wb_valid_nxt = 1'b0;
    w_wb_we_nxt    = 1'b0;
    w_wb_rd_nxt    = r_rd;
    w_wb_data_nxt  = ex_result_i;
    w_err_nxt      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_mem && !w_err) begin
            w_state_nxt = S_REQ;
          end else begin
            w_wb_valid_nxt = 1'b1;
            w_wb_we_nxt    = ex_rd_we_i & (ex_rd_i != '0) & ~w_err;
            w_wb_rd_nxt    = ex_rd_i;
            w_err_nxt      = w_err;
          end
        end
      end
      S_REQ: begin
        if (dmem_gnt_i) begin
          if (r_we) begin
            w_state_nxt    = S_IDLE;
            w_wb_valid_nxt = 1'b1;
          end else begin
            w_state_nxt = S_WAIT_R;
          end
        end
      end
      S_WAIT_R: begin
        if (dmem_rvalid_i) begin
          w_state_nxt    = S_IDLE;
          w_wb_valid_nxt = 1'b1;
          w_wb_we_nxt    = r_rd_we & (r_rd != '0);
          w_wb_data_nxt  = w_load_data;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Latch the access on issue so the bus sees stable values until grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_be    <= 4'h0;
      r_wdata <= '0;
      r_f3    <= 3'b000;
      r_off   <= 2'b00;
      r_rd    <= '0;
      r_rd_we <= 1'b0;
    end else if (w_issue) begin
      r_addr  <= {ex_result_i[XLEN-1:2], 2'b00};
      r_we    <= ex_store_i;
      r_be    <= w_be;
      r_wdata <= w_wdata;
      r_f3    <= ex_funct3_i;
      r_off   <= w_off;
      r_rd    <= ex_rd_i;
      r_rd_we <= ex_rd_we_i;
    end
  end

  // Registered writeback; data fields hold between pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb_valid <= 1'b0;
      r_wb_we    <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      r_wb_valid <= w_wb_valid_nxt;
      r_mem_err  <= w_err_nxt;
      if (w_wb_valid_nxt) begin
        r_wb_we   <= w_wb_we_nxt;
        r_wb_rd   <= w_wb_rd_nxt;
        r_wb_data <= w_wb_data_nxt;
      end
    end
  end

  assign ex_ready_o   = (r_state == S_IDLE);
  assign stall_o      = ~ex_ready_o;
  assign dmem_req_o   = (r_state == S_REQ);
  assign dmem_we_o    = r_we;
  assign dmem_addr_o  = r_addr;
  assign dmem_be_o    = r_be;
  assign dmem_wdata_o = r_wdata;
  assign wb_valid_o   = r_wb_valid;
  assign wb_we_o      = r_wb_we;
  assign wb_rd_o      = r_wb_rd;
  assign wb_data_o    = r_wb_data;
  assign mem_err_o    = r_mem_err;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid_i = 1'b0, ex_load_i = 1'b0, ex_store_i = 1'b0, ex_rd_we_i = 1'b0;
  logic [2:0]  ex_funct3_i = 3'b000;
  logic [31:0] ex_result_i = '0, ex_wdata_i = '0;
  logic [4:0]  ex_rd_i = '0;
  logic        dmem_gnt_i = 1'b0, dmem_rvalid_i = 1'b0;
  logic [31:0] dmem_rdata_i = '0;
  logic        ex_ready_o, stall_o, dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, wb_data_o;
  logic [3:0]  dmem_be_o;
  logic        wb_valid_o, wb_we_o, mem_err_o;
  logic [4:0]  wb_rd_o;

  int n_checks = 0;
  int n_errors = 0;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .stall_o(stall_o),
    .ex_load_i(ex_load_i), .ex_store_i(ex_store_i), .ex_funct3_i(ex_funct3_i),
    .ex_result_i(ex_result_i), .ex_wdata_i(ex_wdata_i), .ex_rd_i(ex_rd_i), .ex_rd_we_i(ex_rd_we_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_we_o(wb_we_o), .wb_rd_o(wb_rd_o),
    .wb_data_o(wb_data_o), .mem_err_o(mem_err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] res, input logic [31:0] wd,
                         input logic [4:0] rd, input logic we);
    ex_valid_i  = 1'b1;
    ex_load_i   = ld;
    ex_store_i  = st;
    ex_funct3_i = f3;
    ex_result_i = res;
    ex_wdata_i  = wd;
    ex_rd_i     = rd;
    ex_rd_we_i  = we;
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [3:0] exp_be,
                         input logic [31:0] exp_data);
    present(1'b1, 1'b0, f3, addr, 32'h0, 5'd7, 1'b1);
    tick();
    ex_valid_i = 1'b0;
    chk({tag, "_req"}, {31'b0, dmem_req_o}, 32'd1);
    chk({tag, "_be"}, {28'b0, dmem_be_o}, {28'b0, exp_be});
    chk({tag, "_addr"}, dmem_addr_o, {addr[31:2], 2'b00});
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = rdata;
    tick();
    dmem_rvalid_i = 1'b0;
    chk({tag, "_wbv"}, {31'b0, wb_valid_o}, 32'd1);
    chk({tag, "_data"}, wb_data_o, exp_data);
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_ready", {31'b0, ex_ready_o}, 32'd1);
    chk("rst_stall", {31'b0, stall_o}, 32'd0);
    chk("rst_req", {31'b0, dmem_req_o}, 32'd0);
    chk("rst_wbv", {31'b0, wb_valid_o}, 32'd0);
    chk("rst_wbdata", wb_data_o, 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // back-to-back ALU ops
    present(1'b0, 1'b0, 3'b000, 32'd5, 32'd0, 5'd1, 1'b1);
    tick();
    chk("alu1_v", {31'b0, wb_valid_o}, 32'd1);
    chk("alu1_we", {31'b0, wb_we_o}, 32'd1);
    chk("alu1_rd", {27'b0, wb_rd_o}, 32'd1);
    chk("alu1_d", wb_data_o, 32'd5);
    present(1'b0, 1'b0, 3'b000, 32'd6, 32'd0, 5'd2, 1'b1);
    tick();
    chk("alu2_v", {31'b0, wb_valid_o}, 32'd1);
    chk("alu2_rd", {27'b0, wb_rd_o}, 32'd2);
    chk("alu2_d", wb_data_o, 32'd6);
    present(1'b0, 1'b0, 3'b000, 32'd7, 32'd0, 5'd0, 1'b1);
    tick();
    ex_valid_i = 1'b0;
    chk("alu3_v", {31'b0, wb_valid_o}, 32'd1);
    chk("alu3_we", {31'b0, wb_we_o}, 32'd0);
    chk("alu3_d", wb_data_o, 32'd7);
    tick();
    chk("alu_idle_v", {31'b0, wb_valid_o}, 32'd0);

    // LW 0x100 with latency and stall checks
    present(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd3, 1'b1);
    tick();
    ex_valid_i = 1'b0;
    chk("lw_req", {31'b0, dmem_req_o}, 32'd1);
    chk("lw_we", {31'b0, dmem_we_o}, 32'd0);
    chk("lw_addr", dmem_addr_o, 32'h100);
    chk("lw_be", {28'b0, dmem_be_o}, 32'hF);
    chk("lw_stall1", {31'b0, stall_o}, 32'd1);
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
    chk("lw_stall2", {31'b0, stall_o}, 32'd1);
    chk("lw_req2", {31'b0, dmem_req_o}, 32'd0);
    chk("lw_wbv2", {31'b0, wb_valid_o}, 32'd0);
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'hDEADBEEF;
    tick();
    dmem_rvalid_i = 1'b0;
    chk("lw_wbv", {31'b0, wb_valid_o}, 32'd1);
    chk("lw_data", wb_data_o, 32'hDEADBEEF);
    chk("lw_we_rd", {31'b0, wb_we_o}, 32'd1);
    chk("lw_rd", {27'b0, wb_rd_o}, 32'd3);
    chk("lw_stall3", {31'b0, stall_o}, 32'd0);

    // sub-word loads
    do_load("lb", 3'b000, 32'h103, 32'h80FFFF00, 4'b1000, 32'hFFFFFF80);
    do_load("lbu", 3'b100, 32'h103, 32'h80FFFF00, 4'b1000, 32'h00000080);
    do_load("lhu", 3'b101, 32'h102, 32'h80FFFF00, 4'b1100, 32'h000080FF);
    do_load("lh", 3'b001, 32'h102, 32'h80FFFF00, 4'b1100, 32'hFFFF80FF);
    do_load("lb1", 3'b000, 32'h101, 32'h00007F00, 4'b0010, 32'h0000007F);

    // SH with grant withheld for 3 cycles
    present(1'b0, 1'b1, 3'b001, 32'h206, 32'h1234ABCD, 5'd4, 1'b1);
    tick();
    ex_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("sh_req", {31'b0, dmem_req_o}, 32'd1);
      chk("sh_we", {31'b0, dmem_we_o}, 32'd1);
      chk("sh_addr", dmem_addr_o, 32'h204);
      chk("sh_be", {28'b0, dmem_be_o}, 32'hC);
      chk("sh_wdata", dmem_wdata_o, 32'hABCDABCD);
      chk("sh_nowb", {31'b0, wb_valid_o}, 32'd0);
      if (i == 3) dmem_gnt_i = 1'b1;
      tick();
    end
    dmem_gnt_i = 1'b0;
    chk("sh_wbv", {31'b0, wb_valid_o}, 32'd1);
    chk("sh_wbwe", {31'b0, wb_we_o}, 32'd0);
    chk("sh_req_off", {31'b0, dmem_req_o}, 32'd0);
    chk("sh_err", {31'b0, mem_err_o}, 32'd0);

    // SB lane replication
    present(1'b0, 1'b1, 3'b000, 32'h101, 32'h00000055, 5'd0, 1'b0);
    tick();
    ex_valid_i = 1'b0;
    chk("sb_be", {28'b0, dmem_be_o}, 32'h2);
    chk("sb_wdata", dmem_wdata_o, 32'h55555555);
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
    chk("sb_wbv", {31'b0, wb_valid_o}, 32'd1);

    // rvalid coincident with gnt must be ignored
    present(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 5'd9, 1'b1);
    tick();
    ex_valid_i    = 1'b0;
    dmem_gnt_i    = 1'b1;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h11111111;
    tick();
    dmem_gnt_i   = 1'b0;
    dmem_rdata_i = 32'h22222222;
    chk("rvg_nowb", {31'b0, wb_valid_o}, 32'd0);
    chk("rvg_stall", {31'b0, stall_o}, 32'd1);
    tick();
    dmem_rvalid_i = 1'b0;
    chk("rvg_wbv", {31'b0, wb_valid_o}, 32'd1);
    chk("rvg_data", wb_data_o, 32'h22222222);

    // error cases: no bus access, error pulse at N+1
    present(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 5'd5, 1'b1);
    tick();
    chk("elw_v", {31'b0, wb_valid_o}, 32'd1);
    chk("elw_err", {31'b0, mem_err_o}, 32'd1);
    chk("elw_we", {31'b0, wb_we_o}, 32'd0);
    chk("elw_req", {31'b0, dmem_req_o}, 32'd0);
    chk("elw_ready", {31'b0, ex_ready_o}, 32'd1);
    present(1'b0, 1'b1, 3'b100, 32'h100, 32'h0, 5'd0, 1'b0);
    tick();
    chk("esbu_err", {31'b0, mem_err_o}, 32'd1);
    chk("esbu_req", {31'b0, dmem_req_o}, 32'd0);
    present(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 5'd6, 1'b1);
    tick();
    chk("ef3_err", {31'b0, mem_err_o}, 32'd1);
    chk("ef3_we", {31'b0, wb_we_o}, 32'd0);
    present(1'b1, 1'b0, 3'b101, 32'h103, 32'h0, 5'd6, 1'b1);
    tick();
    ex_valid_i = 1'b0;
    chk("ehu_err", {31'b0, mem_err_o}, 32'd1);
    tick();
    chk("err_pulse_end", {31'b0, mem_err_o}, 32'd0);
    chk("err_wbv_end", {31'b0, wb_valid_o}, 32'd0);

    // async reset while a request is pending
    present(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 5'd8, 1'b1);
    tick();
    ex_valid_i = 1'b0;
    chk("rreq_req", {31'b0, dmem_req_o}, 32'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("rreq_drop", {31'b0, dmem_req_o}, 32'd0);
    chk("rreq_ready", {31'b0, ex_ready_o}, 32'd1);
    chk("rreq_addr", dmem_addr_o, 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // async reset in WAIT_R, then a late rvalid
    present(1'b1, 1'b0, 3'b010, 32'h80, 32'h0, 5'd8, 1'b1);
    tick();
    ex_valid_i = 1'b0;
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
    chk("rw_stall", {31'b0, stall_o}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rw_ready", {31'b0, ex_ready_o}, 32'd1);
    chk("rw_stall0", {31'b0, stall_o}, 32'd0);
    tick();
    rst = 1'b1;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h33333333;
    tick();
    dmem_rvalid_i = 1'b0;
    chk("rw_nowb", {31'b0, wb_valid_o}, 32'd0);
    chk("rw_ready2", {31'b0, ex_ready_o}, 32'd1);
    tick();
    chk("rw_nowb2", {31'b0, wb_valid_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
